life_board_scanner: RTL and testbench

- Downstream consumer of the LifeCell array: on each generation-complete strobe, snapshots the flat alive vector of a ROWS x COLS board.
- Streams the snapshot out one row per handshake (valid/ready) toward display/host logic.
- Accumulates the population count and maintains a generation counter.
- Protects against a new generation arriving mid-stream with a sticky overrun flag.

---
 rtl/life_pkg.sv | 26 ++
 rtl/life_row_popcount.sv | 20 ++
 rtl/life_board_scanner.sv | 153 +++++++++++++++
 tb/tb_life_board_scanner.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared constants, scanner state encoding and width helpers for the LifeCell board scanner.
package life_pkg;

    localparam int DEFAULT_ROWS = 8;
    localparam int DEFAULT_COLS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // A single-row board still needs a one-bit row index.
    function automatic int idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int pop_width(input int rows, input int cols);
        return $clog2(rows * cols + 1);
    endfunction

    function automatic int row_pop_width(input int cols);
        return $clog2(cols + 1);
    endfunction

endpackage

// File: rtl/life_row_popcount.sv
// Combinational live-cell count of one board row.
module life_row_popcount
    import life_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS
) (
    input  logic [COLS-1:0]                 row,
    output logic [row_pop_width(COLS)-1:0]  count
);

    localparam int RW = row_pop_width(COLS);

    always_comb begin
        count = '0;
        for (int i = 0; i < COLS; i++) begin
            count = count + RW'(row[i]);
        end
    end

endmodule

// File: rtl/life_board_scanner.sv
// Snapshots the LifeCell alive vector on gen_done and streams it out row by row with a population count.
// Optional LIFE_STABLE_DETECT_EN flags a generation identical to the previous scanned one.
module life_board_scanner
    import life_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS,
    parameter int COLS = DEFAULT_COLS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ROWS*COLS-1:0]            cells_alive,
    input  logic                            gen_done,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [COLS-1:0]                 out_row,
    output logic [idx_width(ROWS)-1:0]      out_row_idx,
    output logic                            out_last,
    output logic [pop_width(ROWS,COLS)-1:0] population,
    output logic                            pop_valid,
    output logic [15:0]                     gen_count,
    output logic                            overrun,
    output logic                            stable
);

    localparam int IW = idx_width(ROWS);
    localparam int PW = pop_width(ROWS, COLS);
    localparam int RW = row_pop_width(COLS);
    localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);

    scan_state_t          state;
    scan_state_t          next_state;
    logic [ROWS*COLS-1:0] snapshot;
    logic [IW-1:0]        idx;
    logic [PW-1:0]        acc;
    logic [COLS-1:0]      cur_row;
    logic [RW-1:0]        row_pop;
    logic [15:0]          gen_count_q;
    logic                 at_last;

    assign cur_row   = snapshot[int'(idx) * COLS +: COLS];
    assign at_last   = (idx == LAST_IDX);
    assign gen_count = gen_count_q;

    life_row_popcount #(
        .COLS (COLS)
    ) u_row_pop (
        .row   (cur_row),
        .count (row_pop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_row     = '0;
        out_row_idx = '0;
        case (state)
            IDLE: begin
                if (gen_done) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                out_valid   = 1'b1;
                out_row     = cur_row;
                out_row_idx = idx;
                out_last    = at_last;
                if (out_ready && at_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A generation arriving outside IDLE is dropped; only the sticky overrun records it.
    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot    <= '0;
            idx         <= '0;
            acc         <= '0;
            population  <= '0;
            pop_valid   <= 1'b0;
            gen_count_q <= '0;
            overrun     <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            if (gen_done && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (gen_done) begin
                        snapshot <= cells_alive;
                        idx      <= '0;
                        acc      <= '0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        acc <= acc + PW'(row_pop);
                        if (!at_last) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    population  <= acc;
                    pop_valid   <= 1'b1;
                    gen_count_q <= gen_count_q + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LIFE_STABLE_DETECT_EN
    logic [ROWS*COLS-1:0] prev_snapshot;
    logic                 prev_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_snapshot <= '0;
            prev_valid    <= 1'b0;
            stable        <= 1'b0;
        end else begin
            stable <= 1'b0;
            if (state == DONE) begin
                stable        <= prev_valid && (snapshot == prev_snapshot);
                prev_snapshot <= snapshot;
                prev_valid    <= 1'b1;
            end
        end
    end
`else
    assign stable = 1'b0;
`endif

endmodule

// File: tb/tb_life_board_scanner.sv
// Directed self-checking bench for life_board_scanner on an 8x8 board.
module tb_life_board_scanner;

    logic        clk;
    logic        rst;
    logic [63:0] cells_alive;
    logic        gen_done;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_row;
    logic [2:0]  out_row_idx;
    logic        out_last;
    logic [6:0]  population;
    logic        pop_valid;
    logic [15:0] gen_count;
    logic        overrun;
    logic        stable;

    int tests_run;
    int tests_failed;

    localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;
    localparam logic [63:0] BP_PAT = 64'hFF7F_3F1F_0F07_0301;
    localparam logic [63:0] BLOCK  = 64'h0000_0000_0C0C_0000;

    logic [7:0] glider_rows [8] = '{8'h02, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] bp_rows [8]     = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    bit         rdy_seq [4]     = '{1'b1, 1'b0, 1'b0, 1'b1};

    life_board_scanner #(
        .ROWS (8),
        .COLS (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cells_alive (cells_alive),
        .gen_done    (gen_done),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .population  (population),
        .pop_valid   (pop_valid),
        .gen_count   (gen_count),
        .overrun     (overrun),
        .stable      (stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers are entered and left on a falling edge.
    task automatic do_reset();
        rst      = 1'b1;
        gen_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_scan(input logic [63:0] pat);
        cells_alive = pat;
        gen_done    = 1'b1;
        @(negedge clk);
        gen_done = 1'b0;
    endtask

    task automatic wait_pop(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (pop_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        cells_alive = GLIDER;
        gen_done    = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++; if (out_row !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_out_row: got %h expected 00", out_row); end
        tests_run++; if (out_row_idx !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_out_row_idx: got %0d expected 0", out_row_idx); end
        tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
        tests_run++; if (population !== 7'd0) begin tests_failed++; $display("[TB] FAIL reset_population: got %0d expected 0", population); end
        tests_run++; if (pop_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pop_valid: got %b expected 0", pop_valid); end
        tests_run++; if (gen_count !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_gen_count: got %h expected 0000", gen_count); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        tests_run++; if (stable !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stable: got %b expected 0", stable); end
        gen_done = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_glider();
        out_ready = 1'b1;
        start_scan(GLIDER);
        for (int r = 0; r < 8; r++) begin
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL glider_valid%0d: got %b expected 1", r, out_valid); end
            tests_run++; if (out_row_idx !== 3'(r)) begin tests_failed++; $display("[TB] FAIL glider_idx%0d: got %0d expected %0d", r, out_row_idx, r); end
            tests_run++; if (out_row !== glider_rows[r]) begin tests_failed++; $display("[TB] FAIL glider_row%0d: got %h expected %h", r, out_row, glider_rows[r]); end
            tests_run++; if (out_last !== (r == 7)) begin tests_failed++; $display("[TB] FAIL glider_last%0d: got %b expected %b", r, out_last, (r == 7)); end
            @(negedge clk);
        end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL glider_done_valid: got %b expected 0", out_valid); end
        tests_run++; if (pop_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL glider_early_pop: got %b expected 0", pop_valid); end
        @(negedge clk);
        tests_run++; if (pop_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL glider_pop_valid: got %b expected 1", pop_valid); end
        tests_run++; if (population !== 7'd5) begin tests_failed++; $display("[TB] FAIL glider_population: got %0d expected 5", population); end
        tests_run++; if (gen_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL glider_gen_count: got %0d expected 1", gen_count); end
        @(negedge clk);
        tests_run++; if (pop_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL glider_pop_pulse: got %b expected 0", pop_valid); end
        tests_run++; if (population !== 7'd5) begin tests_failed++; $display("[TB] FAIL glider_pop_hold: got %0d expected 5", population); end
    endtask

    task automatic test_backpressure();
        int  exp_idx;
        bit  done;
        bit  seen;
        exp_idx = 0;
        done    = 1'b0;
        start_scan(BP_PAT);
        for (int k = 0; k < 64 && !done; k++) begin
            out_ready = rdy_seq[k % 4];
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_valid_k%0d: got %b expected 1", k, out_valid); end
            tests_run++; if (out_row_idx !== 3'(exp_idx)) begin tests_failed++; $display("[TB] FAIL bp_idx_k%0d: got %0d expected %0d", k, out_row_idx, exp_idx); end
            tests_run++; if (out_row !== bp_rows[exp_idx]) begin tests_failed++; $display("[TB] FAIL bp_row_k%0d: got %h expected %h", k, out_row, bp_rows[exp_idx]); end
            if (out_ready) begin
                if (exp_idx == 7) done = 1'b1;
                else exp_idx++;
            end
            @(negedge clk);
        end
        tests_run++; if (!done) begin tests_failed++; $display("[TB] FAIL bp_complete: got %0d rows expected 8", exp_idx); end
        out_ready = 1'b1;
        wait_pop(seen);
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL bp_pop_seen: got 0 expected 1"); end
        tests_run++; if (population !== 7'd36) begin tests_failed++; $display("[TB] FAIL bp_population: got %0d expected 36", population); end
        tests_run++; if (gen_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL bp_gen_count: got %0d expected 2", gen_count); end
    endtask

    task automatic test_overrun();
        bit seen;
        out_ready = 1'b1;
        start_scan(GLIDER);
        for (int r = 0; r < 8; r++) begin
            tests_run++; if (out_row_idx !== 3'(r)) begin tests_failed++; $display("[TB] FAIL ovr_idx%0d: got %0d expected %0d", r, out_row_idx, r); end
            tests_run++; if (out_row !== glider_rows[r]) begin tests_failed++; $display("[TB] FAIL ovr_row%0d: got %h expected %h", r, out_row, glider_rows[r]); end
            tests_run++; if (overrun !== (r >= 4)) begin tests_failed++; $display("[TB] FAIL ovr_flag%0d: got %b expected %b", r, overrun, (r >= 4)); end
            if (r == 3) begin
                gen_done    = 1'b1;
                cells_alive = '1;
            end else begin
                gen_done = 1'b0;
            end
            @(negedge clk);
        end
        wait_pop(seen);
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL ovr_pop_seen: got 0 expected 1"); end
        tests_run++; if (population !== 7'd5) begin tests_failed++; $display("[TB] FAIL ovr_population: got %0d expected 5", population); end
        tests_run++; if (gen_count !== 16'd3) begin tests_failed++; $display("[TB] FAIL ovr_gen_count: got %0d expected 3", gen_count); end
        repeat (12) @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovr_dropped_valid: got %b expected 0", out_valid); end
        tests_run++; if (gen_count !== 16'd3) begin tests_failed++; $display("[TB] FAIL ovr_dropped_count: got %0d expected 3", gen_count); end
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovr_sticky: got %b expected 1", overrun); end
        do_reset();
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovr_rst_clear: got %b expected 0", overrun); end
        tests_run++; if (gen_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL ovr_rst_count: got %0d expected 0", gen_count); end
    endtask

    task automatic test_full_empty();
        bit seen;
        out_ready = 1'b1;
        start_scan('1);
        wait_pop(seen);
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL full_pop_seen: got 0 expected 1"); end
        tests_run++; if (population !== 7'd64) begin tests_failed++; $display("[TB] FAIL full_population: got %0d expected 64", population); end
        tests_run++; if (gen_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL full_gen_count: got %0d expected 1", gen_count); end
        start_scan('0);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_accept: got %b expected 1", out_valid); end
        wait_pop(seen);
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL empty_pop_seen: got 0 expected 1"); end
        tests_run++; if (population !== 7'd0) begin tests_failed++; $display("[TB] FAIL empty_population: got %0d expected 0", population); end
        tests_run++; if (gen_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL empty_gen_count: got %0d expected 2", gen_count); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun); end
    endtask

    // Preload the counter near its limit instead of running 65535 scans.
    task automatic test_gen_wrap();
        bit seen;
        @(negedge clk);
        force dut.gen_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.gen_count_q;
        @(negedge clk);
        tests_run++; if (gen_count !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL wrap_preload: got %h expected ffff", gen_count); end
        start_scan(GLIDER);
        wait_pop(seen);
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL wrap_pop_seen: got 0 expected 1"); end
        tests_run++; if (gen_count !== 16'h0000) begin tests_failed++; $display("[TB] FAIL wrap_gen_count: got %h expected 0000", gen_count); end
        tests_run++; if (population !== 7'd5) begin tests_failed++; $display("[TB] FAIL wrap_population: got %0d expected 5", population); end
    endtask

    task automatic test_reset_midscan();
        bit seen;
        out_ready = 1'b1;
        start_scan(BP_PAT);
        wait_pop(seen);
        tests_run++; if (gen_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL mid_pre_count: got %0d expected 1", gen_count); end
        start_scan(GLIDER);
        repeat (5) @(negedge clk);
        tests_run++; if (out_row_idx !== 3'd5) begin tests_failed++; $display("[TB] FAIL mid_idx: got %0d expected 5", out_row_idx); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_valid: got %b expected 0", out_valid); end
        wait_pop(seen);
        tests_run++; if (seen) begin tests_failed++; $display("[TB] FAIL mid_no_pop: got 1 expected 0"); end
        tests_run++; if (gen_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL mid_gen_count: got %0d expected 0", gen_count); end
        tests_run++; if (population !== 7'd0) begin tests_failed++; $display("[TB] FAIL mid_population: got %0d expected 0", population); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_idle_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_stable();
        bit   seen;
        logic exp_second;
`ifdef LIFE_STABLE_DETECT_EN
        exp_second = 1'b1;
`else
        exp_second = 1'b0;
`endif
        do_reset();
        out_ready = 1'b1;
        start_scan(BLOCK);
        wait_pop(seen);
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL stable1_pop_seen: got 0 expected 1"); end
        tests_run++; if (population !== 7'd4) begin tests_failed++; $display("[TB] FAIL stable1_population: got %0d expected 4", population); end
        tests_run++; if (stable !== 1'b0) begin tests_failed++; $display("[TB] FAIL stable1_first: got %b expected 0", stable); end
        start_scan(BLOCK);
        wait_pop(seen);
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL stable2_pop_seen: got 0 expected 1"); end
        tests_run++; if (stable !== exp_second) begin tests_failed++; $display("[TB] FAIL stable2_repeat: got %b expected %b", stable, exp_second); end
        @(negedge clk);
        tests_run++; if (stable !== 1'b0) begin tests_failed++; $display("[TB] FAIL stable2_pulse: got %b expected 0", stable); end
        start_scan(GLIDER);
        wait_pop(seen);
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL stable3_pop_seen: got 0 expected 1"); end
        tests_run++; if (stable !== 1'b0) begin tests_failed++; $display("[TB] FAIL stable3_changed: got %b expected 0", stable); end
        tests_run++; if (gen_count !== 16'd3) begin tests_failed++; $display("[TB] FAIL stable_gen_count: got %0d expected 3", gen_count); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        gen_done     = 1'b0;
        out_ready    = 1'b0;
        cells_alive  = '0;
        test_reset();
        test_glider();
        test_backpressure();
        test_overrun();
        test_full_empty();
        test_gen_wrap();
        test_reset_midscan();
        test_stable();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
